// File: rtl/rx_hdr_extract_pkg.sv
// rx_hdr_extract_pkg
//   Shared definitions for the RX header extractor: stream/tuple widths,
//   Ethernet/IPv4 byte offsets (no VLAN, IHL=5), the parser state type,
//   the {slot, header} tag used by the FW FIFO, and the tuple lane mapping.
package rx_hdr_extract_pkg;

   localparam int unsigned DATA_WIDTH    = 8;
   localparam int unsigned HEADER_BIT    = 104;
   localparam int unsigned SLOT_W        = 4;
   localparam int unsigned CNT_W         = 11;

   localparam int OFF_ETYPE     = 12;
   localparam int OFF_VERIHL    = 14;
   localparam int OFF_PROTO     = 23;
   localparam int OFF_SRCIP     = 26;
   localparam int OFF_DSTIP     = 30;
   localparam int OFF_SRCPT     = 34;
   localparam int OFF_DSTPT     = 36;
   localparam int MIN_HDR_BYTES = 38;

   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  VERIHL_IPV4 = 8'h45;

   typedef enum logic [1:0] {IDLE, PARSE, DRAIN, EMIT} hdrx_state_t;

   typedef struct packed {
      logic [SLOT_W-1:0]     slot;
      logic [HEADER_BIT-1:0] header;
   } hdr_tag_t;

   // Bit position of the 8-bit tuple lane written by frame byte idx, or -1
   // when that byte carries no tuple field. Tuple layout is
   // {dstpt, srcpt, dstip, srcip, proto}; multi-byte fields are big-endian.
   function automatic int hdr_lane_lsb(input logic [CNT_W-1:0] idx);
      int i;
      i = int'(idx);
      if (i == OFF_PROTO)                              return 0;
      if (i >= OFF_SRCIP && i < OFF_SRCIP + 4)         return 8  + 8 * (OFF_SRCIP + 3 - i);
      if (i >= OFF_DSTIP && i < OFF_DSTIP + 4)         return 40 + 8 * (OFF_DSTIP + 3 - i);
      if (i >= OFF_SRCPT && i < OFF_SRCPT + 2)         return 72 + 8 * (OFF_SRCPT + 1 - i);
      if (i >= OFF_DSTPT && i < OFF_DSTPT + 2)         return 88 + 8 * (OFF_DSTPT + 1 - i);
      return -1;
   endfunction

endpackage

// File: rtl/rx_hdr_extract_if.sv
// rx_hdr_extract_if
//   Byte-stream input and tuple output bundle of the RX header extractor.
//   slave : parser side (consumes the byte stream, produces the tuple)
//   master: environment side (Ethernet RX + FW FIFO write port)
//   Signals: in_valid/in_data/in_last/in_ready, slot_in,
//            hdr_valid/hdr_ready/hdr_data/hdr_slot/hdr_is_ipv4,
//            frame_err, byte_cnt.
interface rx_hdr_extract_if;
   import rx_hdr_extract_pkg::*;

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;
   logic [SLOT_W-1:0]     slot_in;
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [HEADER_BIT-1:0] hdr_data;
   logic [SLOT_W-1:0]     hdr_slot;
   logic                  hdr_is_ipv4;
   logic                  frame_err;
   logic [CNT_W-1:0]      byte_cnt;

   modport slave (
      input  in_valid, in_data, in_last, slot_in, hdr_ready,
      output in_ready, hdr_valid, hdr_data, hdr_slot, hdr_is_ipv4, frame_err, byte_cnt
   );

   modport master (
      output in_valid, in_data, in_last, slot_in, hdr_ready,
      input  in_ready, hdr_valid, hdr_data, hdr_slot, hdr_is_ipv4, frame_err, byte_cnt
   );

endinterface

// File: rtl/rx_hdr_extract.sv
// rx_hdr_extract
//   Streaming parser between the Ethernet RX byte stream and the firewall
//   request FIFO. Counts the bytes of each Ethernet/IPv4 frame, captures the
//   104-bit 5-tuple, tags it with the PRT slot sampled at byte 0 and offers
//   {slot, header} on a valid/ready port. Runt (<38 bytes) and oversize
//   (FRAME_SIZE bytes without in_last) frames pulse frame_err and are dropped.
// Ports
//   clk   : clock
//   reset : synchronous, active-high
//   hif   : rx_hdr_extract_if.slave (byte stream in, tuple out, status)
module rx_hdr_extract
   import rx_hdr_extract_pkg::*;
#(
   parameter int unsigned FRAME_SIZE = 1500
) (
   input  logic                   clk,
   input  logic                   reset,
   rx_hdr_extract_if.slave        hif
);

   localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_SIZE);
   localparam logic [CNT_W-1:0] MIN_LIM   = CNT_W'(MIN_HDR_BYTES);

   hdrx_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   hdr_tag_t         tag_q, tag_d;
   logic             ipv4_q, ipv4_d;
   logic [15:0]      etype_q, etype_d;
   logic [7:0]       verihl_q, verihl_d;
   logic             err_q, err_d;
   logic             xfer_in;
   int               lsb;

   assign hif.in_ready    = (state_q != EMIT);
   assign hif.hdr_valid   = (state_q == EMIT);
   assign hif.hdr_data    = tag_q.header;
   assign hif.hdr_slot    = tag_q.slot;
   assign hif.hdr_is_ipv4 = ipv4_q;
   assign hif.frame_err   = err_q;
   assign hif.byte_cnt    = cnt_q;

   assign xfer_in = hif.in_valid & hif.in_ready;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      ipv4_d   = ipv4_q;
      etype_d  = etype_q;
      verihl_d = verihl_q;
      err_d    = 1'b0;
      lsb      = hdr_lane_lsb(cnt_q);

      unique case (state_q)
         IDLE: begin
            if (xfer_in) begin
               // A fresh frame starts from an all-zero tuple so lanes never
               // leak from the previous frame.
               tag_d  = '0;
               ipv4_d = 1'b0;
               if (hif.in_last) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = PARSE;
                  cnt_d      = CNT_W'(1);
                  tag_d.slot = hif.slot_in;
               end
            end
         end

         PARSE: begin
            if (xfer_in) begin
               if (lsb >= 0) tag_d.header[lsb +: 8] = hif.in_data;
               if (cnt_q == CNT_W'(OFF_ETYPE))     etype_d[15:8] = hif.in_data;
               if (cnt_q == CNT_W'(OFF_ETYPE + 1)) etype_d[7:0]  = hif.in_data;
               if (cnt_q == CNT_W'(OFF_VERIHL))    verihl_d      = hif.in_data;

               if (hif.in_last) begin
                  if (cnt_inc >= MIN_LIM) begin
                     // Bytes 12..14 are already registered by the time the
                     // last byte (index >= 37) arrives.
                     state_d = EMIT;
                     cnt_d   = cnt_inc;
                     ipv4_d  = (etype_q == ETYPE_IPV4) && (verihl_q == VERIHL_IPV4);
                     if (!ipv4_d) tag_d.header = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                     cnt_d   = '0;
                     tag_d   = '0;
                     ipv4_d  = 1'b0;
                  end
               end else if (cnt_inc == FRAME_LIM) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
                  cnt_d   = cnt_inc;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         DRAIN: begin
            if (xfer_in && hif.in_last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         EMIT: begin
            if (hif.hdr_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tag_q    <= '0;
         ipv4_q   <= 1'b0;
         etype_q  <= '0;
         verihl_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tag_q    <= tag_d;
         ipv4_q   <= ipv4_d;
         etype_q  <= etype_d;
         verihl_q <= verihl_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_rx_hdr_extract.sv
module tb_rx_hdr_extract;
   import rx_hdr_extract_pkg::*;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int            len;
      logic [15:0]   et;
      logic [7:0]    vh;
      logic [7:0]    pr;
      logic [31:0]   sip;
      logic [31:0]   dip;
      logic [15:0]   sp;
      logic [15:0]   dp;
      logic [3:0]    slot;
      int            hold;
      int            exp_emit;
      int            exp_err;
      logic [103:0]  exp_hdr;
      logic          exp_ipv4;
   } vec_t;

   localparam logic [103:0] TCP_HDR = {16'h0050, 16'h04D2, 32'h0A000002, 32'h0A000001, 8'h06};
   localparam logic [103:0] FOL_HDR = {16'h0035, 16'h14E9, 32'hC0A80114, 32'hC0A8010A, 8'h11};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rx_hdr_extract_if bus();

   rx_hdr_extract #(.FRAME_SIZE(1500)) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Stream being driven: {last, byte} plus slot per byte.
   logic [8:0]   sb[$];
   logic [3:0]   ss[$];
   // Observations of the last run_stream.
   logic [103:0] g_hdr[$];
   logic [3:0]   g_slot[$];
   logic         g_ipv4[$];
   int           g_cnt[$];
   int           e_idx[$];
   int           e_cnt[$];
   int           stall_bad, stab_bad, lat_bad;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bq_t build(input int len, input logic [15:0] et, input logic [7:0] vh,
                                 input logic [7:0] pr, input logic [31:0] sip, input logic [31:0] dip,
                                 input logic [15:0] sp, input logic [15:0] dp);
      bq_t f;
      logic [7:0] hb[38];
      for (int i = 0; i < 38; i++) hb[i] = 8'($urandom);
      hb[12] = et[15:8];
      hb[13] = et[7:0];
      hb[14] = vh;
      hb[23] = pr;
      for (int k = 0; k < 4; k++) begin
         hb[26 + k] = sip[31 - 8*k -: 8];
         hb[30 + k] = dip[31 - 8*k -: 8];
      end
      for (int k = 0; k < 2; k++) begin
         hb[34 + k] = sp[15 - 8*k -: 8];
         hb[36 + k] = dp[15 - 8*k -: 8];
      end
      for (int i = 0; i < len; i++) f.push_back(i < 38 ? hb[i] : 8'($urandom));
      return f;
   endfunction

   // Reference: outcome of a frame from its byte list alone.
   function automatic void model(input bq_t f, output logic emit, output logic err,
                                 output logic ipv4, output logic [103:0] hdr);
      int n;
      n    = f.size();
      err  = (n < 38) || (n > 1500);
      emit = !err;
      ipv4 = emit && (f[12] == 8'h08) && (f[13] == 8'h00) && (f[14] == 8'h45);
      hdr  = ipv4 ? {f[36], f[37], f[34], f[35], f[30], f[31], f[32], f[33],
                     f[26], f[27], f[28], f[29], f[23]} : '0;
   endfunction

   task automatic add_frame(input bq_t f, input logic [3:0] slot);
      for (int i = 0; i < f.size(); i++) begin
         sb.push_back({(i == f.size() - 1), f[i]});
         ss.push_back(slot);
      end
   endtask

   // Drives sb/ss back to back, holds hdr_ready low for 'hold' cycles of each
   // hdr_valid (hold<0: random 0..3), records every emit and every error.
   task automatic run_stream(input int gap_pct, input int hold);
      int idx = 0, cyc = 0, last_cyc = -10, post = 0, hold_left, budget;
      bit open = 0;
      logic [103:0] h0 = '0;
      logic [3:0]   s0 = '0;
      logic         i0 = 1'b0;
      budget    = 3 * sb.size() + 200;
      hold_left = (hold < 0) ? int'($urandom_range(3)) : hold;
      g_hdr.delete(); g_slot.delete(); g_ipv4.delete(); g_cnt.delete();
      e_idx.delete(); e_cnt.delete();
      stall_bad = 0; stab_bad = 0; lat_bad = 0;
      while ((idx < sb.size() || open || post < 4) && cyc < budget) begin
         bus.in_valid = (idx < sb.size()) && (int'($urandom_range(99)) >= gap_pct);
         if (idx < sb.size()) begin
            {bus.in_last, bus.in_data} = sb[idx];
            bus.slot_in = ss[idx];
         end else begin
            bus.in_last = 1'b0;
            bus.in_data = '0;
            bus.slot_in = '0;
         end
         bus.hdr_ready = (hold_left == 0);
         @(negedge clk);
         if (bus.in_ready !== !bus.hdr_valid) stall_bad++;
         if (bus.frame_err === 1'b1) begin
            e_idx.push_back(idx);
            e_cnt.push_back(int'(bus.byte_cnt));
         end
         if (bus.hdr_valid === 1'b1) begin
            if (!open) begin
               open = 1;
               h0 = bus.hdr_data; s0 = bus.hdr_slot; i0 = bus.hdr_is_ipv4;
               if (cyc != last_cyc + 1) lat_bad++;
               g_cnt.push_back(int'(bus.byte_cnt));
            end else if ({bus.hdr_data, bus.hdr_slot, bus.hdr_is_ipv4} !== {h0, s0, i0}) begin
               stab_bad++;
            end
            if (bus.hdr_ready) begin
               g_hdr.push_back(h0); g_slot.push_back(s0); g_ipv4.push_back(i0);
               open = 0;
               hold_left = (hold < 0) ? int'($urandom_range(3)) : hold;
            end else begin
               hold_left--;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            if (bus.in_last) last_cyc = cyc;
            idx++;
         end
         if (idx >= sb.size() && !open) post++;
         cyc++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("stream_in_budget", (cyc < budget), 1);
      sb.delete(); ss.delete();
   endtask

   // Plain byte push without checks, used to park the DUT mid-frame or in EMIT.
   task automatic send_raw(input bq_t f, input int nbytes, input logic [3:0] slot);
      int k = 0, guard = 0;
      bus.hdr_ready = 1'b0;
      while (k < nbytes && guard < 4 * nbytes + 20) begin
         bus.in_valid = 1'b1;
         bus.in_data  = f[k];
         bus.in_last  = (k == f.size() - 1);
         bus.slot_in  = slot;
         @(negedge clk);
         if (bus.in_ready) k++;
         guard++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("raw_sent", k, nbytes);
   endtask

   task automatic check_reset_vals(input string t);
      chk({t, "_in_ready"},    bus.in_ready,    1);
      chk({t, "_hdr_valid"},   bus.hdr_valid,   0);
      chk({t, "_hdr_data"},    bus.hdr_data,    0);
      chk({t, "_hdr_slot"},    bus.hdr_slot,    0);
      chk({t, "_hdr_is_ipv4"}, bus.hdr_is_ipv4, 0);
      chk({t, "_frame_err"},   bus.frame_err,   0);
      chk({t, "_byte_cnt"},    bus.byte_cnt,    0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
   endtask

   vec_t tbl[9];
   bq_t  fol, tcp, f;

   initial begin
      tbl[0] = '{64,   16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234,  16'd80,   4'd3, 0, 1, 0, TCP_HDR, 1'b1};
      tbl[1] = '{64,   16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234,  16'd80,   4'd3, 5, 1, 0, TCP_HDR, 1'b1};
      tbl[2] = '{20,   16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234,  16'd80,   4'd1, 0, 0, 1, '0, 1'b0};
      tbl[3] = '{60,   16'h0806, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234,  16'd80,   4'd5, 1, 1, 0, '0, 1'b0};
      tbl[4] = '{38,   16'h0800, 8'h45, 8'h11, 32'h01020304, 32'h05060708, 16'h1111,  16'h2222, 4'hF, 0, 1, 0,
                 {16'h2222, 16'h1111, 32'h05060708, 32'h01020304, 8'h11}, 1'b1};
      tbl[5] = '{37,   16'h0800, 8'h45, 8'h11, 32'h01020304, 32'h05060708, 16'h1111,  16'h2222, 4'd2, 0, 0, 1, '0, 1'b0};
      tbl[6] = '{1,    16'h0800, 8'h45, 8'h11, 32'h01020304, 32'h05060708, 16'h1111,  16'h2222, 4'd2, 0, 0, 1, '0, 1'b0};
      tbl[7] = '{50,   16'h0800, 8'h46, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234,  16'd80,   4'd7, 0, 1, 0, '0, 1'b0};
      tbl[8] = '{1500, 16'h0800, 8'h45, 8'h06, 32'hC0000201, 32'hC6336402, 16'hC000,  16'h01BB, 4'd8, 2, 1, 0,
                 {16'h01BB, 16'hC000, 32'hC6336402, 32'hC0000201, 8'h06}, 1'b1};

      fol = build(64, 16'h0800, 8'h45, 8'h11, 32'hC0A8010A, 32'hC0A80114, 16'd5353, 16'd53);
      tcp = build(64, 16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);

      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      bus.slot_in = '0; bus.hdr_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;

      // Table: each row followed back-to-back by a known 64B UDP frame.
      for (int r = 0; r < 9; r++) begin
         f = build(tbl[r].len, tbl[r].et, tbl[r].vh, tbl[r].pr, tbl[r].sip, tbl[r].dip, tbl[r].sp, tbl[r].dp);
         add_frame(f, tbl[r].slot);
         add_frame(fol, 4'd9);
         run_stream(0, tbl[r].hold);
         chk($sformatf("r%0d_emits", r), g_hdr.size(), tbl[r].exp_emit + 1);
         chk($sformatf("r%0d_errs", r),  e_idx.size(), tbl[r].exp_err);
         if (tbl[r].exp_emit == 1 && g_hdr.size() == 2) begin
            chk($sformatf("r%0d_hdr", r),  g_hdr[0],  tbl[r].exp_hdr);
            chk($sformatf("r%0d_slot", r), g_slot[0], tbl[r].slot);
            chk($sformatf("r%0d_ipv4", r), g_ipv4[0], tbl[r].exp_ipv4);
            chk($sformatf("r%0d_cnt", r),  g_cnt[0],  tbl[r].len);
         end
         if (tbl[r].exp_err == 1 && e_idx.size() == 1) begin
            chk($sformatf("r%0d_err_at", r),  e_idx[0], tbl[r].len);
            chk($sformatf("r%0d_err_cnt", r), e_cnt[0], 0);
         end
         if (g_hdr.size() > 0) begin
            chk($sformatf("r%0d_fol_hdr", r),  g_hdr[g_hdr.size()-1],  FOL_HDR);
            chk($sformatf("r%0d_fol_slot", r), g_slot[g_slot.size()-1], 9);
            chk($sformatf("r%0d_fol_ipv4", r), g_ipv4[g_ipv4.size()-1], 1);
         end
         chk($sformatf("r%0d_in_ready_vs_emit", r), stall_bad, 0);
         chk($sformatf("r%0d_hdr_stable", r),       stab_bad,  0);
         chk($sformatf("r%0d_valid_latency", r),    lat_bad,   0);
      end

      // Oversize: 1510 bytes, in_last only on the final one.
      f = build(1510, 16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
      add_frame(f, 4'd2);
      add_frame(fol, 4'd9);
      run_stream(0, 0);
      chk("ovs_emits", g_hdr.size(), 1);
      chk("ovs_errs",  e_idx.size(), 1);
      if (e_idx.size() == 1) begin
         chk("ovs_err_at",  e_idx[0], 1500);
         chk("ovs_err_cnt", e_cnt[0], 1500);
      end
      if (g_hdr.size() == 1) chk("ovs_fol_hdr", g_hdr[0], FOL_HDR);
      chk("ovs_in_ready", stall_bad, 0);

      // Reset while byte 30 is on the bus.
      send_raw(tcp, 30, 4'd3);
      bus.in_valid = 1'b1; bus.in_data = tcp[30]; bus.slot_in = 4'd3;
      pulse_reset();
      bus.in_valid = 1'b0;
      check_reset_vals("rst_mid");
      begin
         int seen = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.hdr_valid === 1'b1) seen++;
         end
         chk("rst_mid_no_emit", seen, 0);
      end
      @(posedge clk); #1;
      add_frame(tcp, 4'd3);
      run_stream(0, 0);
      chk("rst_mid_next_emits", g_hdr.size(), 1);
      if (g_hdr.size() == 1) begin
         chk("rst_mid_next_hdr",  g_hdr[0],  TCP_HDR);
         chk("rst_mid_next_slot", g_slot[0], 3);
      end

      // Reset while the tuple is waiting in EMIT.
      send_raw(tcp, 64, 4'd6);
      begin
         int w = 0;
         @(negedge clk);
         while (bus.hdr_valid !== 1'b1 && w < 5) begin
            @(negedge clk);
            w++;
         end
         chk("rst_emit_reached", bus.hdr_valid, 1);
      end
      @(posedge clk); #1;
      pulse_reset();
      check_reset_vals("rst_emit");
      @(posedge clk); #1;

      // Random frames with input gaps and random back-pressure.
      begin
         logic [103:0] x_hdr[$];
         logic [3:0]   x_slot[$];
         logic         x_ipv4[$];
         int           x_len[$];
         int           x_eidx[$];
         int           start = 0;
         for (int n = 0; n < 25; n++) begin
            int len, sel;
            logic [15:0] et;
            logic [7:0]  vh;
            logic [3:0]  sl;
            logic em, er, ip;
            logic [103:0] hd;
            len = ($urandom_range(9) < 3) ? int'($urandom_range(1, 37)) : int'($urandom_range(38, 120));
            sel = int'($urandom_range(9));
            et = 16'h0800; vh = 8'h45;
            if (sel == 7) et = 16'h0806;
            if (sel == 8) et = 16'h0801;
            if (sel == 9) vh = 8'h46;
            sl = 4'($urandom);
            f = build(len, et, vh, 8'($urandom), $urandom, $urandom, 16'($urandom), 16'($urandom));
            model(f, em, er, ip, hd);
            if (em) begin
               x_hdr.push_back(hd); x_slot.push_back(sl); x_ipv4.push_back(ip); x_len.push_back(len);
            end
            if (er) x_eidx.push_back(start + len);
            start += len;
            add_frame(f, sl);
         end
         run_stream(15, -1);
         chk("rnd_emits", g_hdr.size(), x_hdr.size());
         chk("rnd_errs",  e_idx.size(), x_eidx.size());
         for (int i = 0; i < x_hdr.size() && i < g_hdr.size(); i++) begin
            chk($sformatf("rnd%0d_hdr", i),  g_hdr[i],  x_hdr[i]);
            chk($sformatf("rnd%0d_slot", i), g_slot[i], x_slot[i]);
            chk($sformatf("rnd%0d_ipv4", i), g_ipv4[i], x_ipv4[i]);
            chk($sformatf("rnd%0d_cnt", i),  g_cnt[i],  x_len[i]);
         end
         for (int i = 0; i < x_eidx.size() && i < e_idx.size(); i++)
            chk($sformatf("rnd%0d_err_at", i), e_idx[i], x_eidx[i]);
         chk("rnd_in_ready",      stall_bad, 0);
         chk("rnd_hdr_stable",    stab_bad,  0);
         chk("rnd_valid_latency", lat_bad,   0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
